// File: rtl/gpioemu_host_master.sv
// gpioemu_host_master: bus initiator that runs one multiply job on the gpioemu slave port
// (write A1/A2/start, poll status, read W and L) and returns the result over valid/ready.
module gpioemu_host_master #(
    parameter logic [15:0] ADDR_A1    = 16'h0380,
    parameter logic [15:0] ADDR_A2    = 16'h0388,
    parameter logic [15:0] ADDR_W     = 16'h0390,
    parameter logic [15:0] ADDR_L     = 16'h0398,
    parameter logic [15:0] ADDR_CTRL  = 16'h03A0,
    parameter int          STROBE_CYC = 2,
    parameter int          GAP_CYC    = 2,
    parameter int          POLL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [23:0] job_a1,
    input  logic [23:0] job_a2,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_w,
    output logic [23:0] res_l,
    output logic        res_timeout,
    output logic        busy,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);
    localparam logic [2:0] S_IDLE = 3'd0, S_WR_A1 = 3'd1, S_WR_A2 = 3'd2, S_WR_CTRL = 3'd3,
                           S_POLL = 3'd4, S_RD_W = 3'd5, S_RD_L = 3'd6, S_RESP = 3'd7;
    localparam logic [1:0] P_SETUP = 2'd0, P_STROBE = 2'd1, P_HOLD = 2'd2, P_GAP = 2'd3;

    logic [2:0]  r_state;
    logic [1:0]  r_ph;
    logic [7:0]  r_cnt;
    logic [15:0] r_polls;
    logic [23:0] r_a1, r_a2, r_res_l;
    logic [31:0] r_res_w;
    logic        r_timeout;

    logic        w_access, w_act, w_is_wr, w_done;
    logic [15:0] w_addr, w_poll_next;
    logic [31:0] w_wdata;
    logic [2:0]  w_next;

    assign w_access    = r_state != S_IDLE && r_state != S_RESP;
    assign w_act       = w_access && r_ph != P_GAP;
    assign w_is_wr     = r_state == S_WR_A1 || r_state == S_WR_A2 || r_state == S_WR_CTRL;
    assign w_done      = sdata_in[1:0] == 2'b11;
    assign w_poll_next = r_polls + 16'd1;

    always_comb begin
        w_addr  = r_state == S_WR_A1 ? ADDR_A1 :
                  r_state == S_WR_A2 ? ADDR_A2 :
                  r_state == S_RD_W  ? ADDR_W  :
                  r_state == S_RD_L  ? ADDR_L  : ADDR_CTRL;
        w_wdata = r_state == S_WR_A1 ? {8'h0, r_a1} :
                  r_state == S_WR_A2 ? {8'h0, r_a2} : 32'h1;
        w_next  = r_state == S_WR_A1   ? S_WR_A2 :
                  r_state == S_WR_A2   ? S_WR_CTRL :
                  r_state == S_WR_CTRL ? S_POLL :
                  r_state == S_RD_W    ? S_RD_L :
                  r_state == S_RD_L    ? S_RESP :
                  w_done               ? S_RD_W :
                  w_poll_next == 16'(POLL_LIMIT) ? S_RESP : S_POLL;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state   <= S_IDLE;
            r_ph      <= P_SETUP;
            r_cnt     <= '0;
            r_polls   <= '0;
            r_a1      <= '0;
            r_a2      <= '0;
            r_res_w   <= '0;
            r_res_l   <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (job_valid) begin
                r_a1    <= job_a1;
                r_a2    <= job_a2;
                r_polls <= '0;
                r_ph    <= P_SETUP;
                r_state <= S_WR_A1;
            end
        end else if (r_state == S_RESP) begin
            if (res_ready) r_state <= S_IDLE;
        end else begin
            case (r_ph)
                P_SETUP: begin
                    r_ph  <= P_STROBE;
                    r_cnt <= '0;
                end
                P_STROBE: begin
                    if (r_cnt == 8'(STROBE_CYC - 1)) r_ph <= P_HOLD;
                    else r_cnt <= r_cnt + 8'd1;
                end
                P_HOLD: begin
                    // Last access of a job goes straight to RESP; no trailing gap.
                    r_state <= w_next;
                    r_ph    <= (GAP_CYC == 0) ? P_SETUP : P_GAP;
                    r_cnt   <= '0;
                    if (r_state == S_POLL) r_polls <= w_poll_next;
                    if (r_state == S_POLL && w_next == S_RESP) begin
                        r_res_w   <= '0;
                        r_res_l   <= '0;
                        r_timeout <= 1'b1;
                    end
                    if (r_state == S_RD_W) r_res_w <= sdata_in;
                    if (r_state == S_RD_L) begin
                        r_res_l   <= sdata_in[23:0];
                        r_timeout <= 1'b0;
                    end
                end
                default: begin
                    if (r_cnt == 8'(GAP_CYC - 1)) r_ph <= P_SETUP;
                    else r_cnt <= r_cnt + 8'd1;
                end
            endcase
        end
    end

    assign job_ready   = r_state == S_IDLE;
    assign res_valid   = r_state == S_RESP;
    assign busy        = r_state != S_IDLE;
    assign res_w       = r_res_w;
    assign res_l       = r_res_l;
    assign res_timeout = r_timeout;
    assign saddress    = w_act ? w_addr : '0;
    assign sdata_out   = (w_act && w_is_wr) ? w_wdata : '0;
    assign swr         = w_is_wr && r_ph == P_STROBE;
    assign srd         = w_access && !w_is_wr && r_ph == P_STROBE;
endmodule

// File: tb/tb_gpioemu_host_master.sv
// tb_gpioemu_host_master: directed bench with a behavioural gpioemu slave and a bus-protocol monitor.
module tb_gpioemu_host_master;
    logic        clk = 0, n_reset = 0, job_valid = 0, res_ready = 0;
    logic [23:0] job_a1 = 0, job_a2 = 0;
    logic [31:0] sdata_in = 0;
    logic        job_ready, res_valid, res_timeout, busy, srd, swr;
    logic [31:0] res_w, sdata_out;
    logic [23:0] res_l;
    logic [15:0] saddress;

    int checks = 0, errors = 0;
    int nr0, nw0, lat;
    bit mon_en = 0;

    // Slave behaviour knobs
    int         busy_polls = 0;
    logic [1:0] busy_stat = 2'b00;
    bit         stuck = 0;

    always #5 clk = ~clk;

    gpioemu_host_master #(.POLL_LIMIT(4)) dut (
        .clk(clk), .n_reset(n_reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_a1(job_a1), .job_a2(job_a2), .res_valid(res_valid), .res_ready(res_ready),
        .res_w(res_w), .res_l(res_l), .res_timeout(res_timeout), .busy(busy),
        .saddress(saddress), .srd(srd), .swr(swr), .sdata_out(sdata_out), .sdata_in(sdata_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: acts on strobe rising edges, computes W = A1*A2 and L = popcount(W)
    logic        p_srd = 0, p_swr = 0;
    logic [23:0] s_a1 = 0, s_a2 = 0;
    int          ctrl_reads = 0, nr = 0, nw = 0;
    logic [15:0] rlog [256];
    logic [15:0] wa [256];
    logic [31:0] wd [256];
    logic [47:0] prod;
    assign prod = {24'h0, s_a1} * {24'h0, s_a2};

    always @(posedge clk) begin
        p_srd <= srd;
        p_swr <= swr;
        if (swr && !p_swr) begin
            wa[nw[7:0]] <= saddress;
            wd[nw[7:0]] <= sdata_out;
            nw <= nw + 1;
            if (saddress == 16'h0380) s_a1 <= sdata_out[23:0];
            if (saddress == 16'h0388) s_a2 <= sdata_out[23:0];
            if (saddress == 16'h03A0) ctrl_reads <= 0;
        end
        if (srd && !p_srd) begin
            rlog[nr[7:0]] <= saddress;
            nr <= nr + 1;
            sdata_in <= saddress == 16'h03A0 ?
                            ((stuck || ctrl_reads < busy_polls) ? {30'b0, busy_stat} : 32'h3) :
                        saddress == 16'h0390 ? prod[31:0] :
                        saddress == 16'h0398 ? 32'($countones(prod[31:0])) : 32'hDEADBEEF;
            if (saddress == 16'h03A0) ctrl_reads <= ctrl_reads + 1;
        end
    end

    // Protocol monitor: exclusive strobes, strobe width, address stable SETUP..HOLD
    int          run = 0;
    logic        pstr = 0;
    logic [15:0] paddr = 0;
    always @(negedge clk) begin
        if (n_reset && mon_en) begin
            chk("strobe_excl", {31'b0, srd & swr}, 32'd0);
            if (srd | swr | pstr) chk("addr_stable", {16'h0, saddress}, {16'h0, paddr});
            if (!(srd | swr) && pstr) chk("strobe_width", 32'(run), 32'd2);
            if (srd) chk("wdata_idle_on_read", sdata_out, 32'd0);
        end
        run   <= (srd | swr) ? run + 1 : 0;
        pstr  <= srd | swr;
        paddr <= saddress;
    end

    task automatic run_job(input logic [23:0] a1, input logic [23:0] a2, output int l);
        @(negedge clk);
        job_a1 = a1;
        job_a2 = a2;
        job_valid = 1;
        @(negedge clk);
        job_valid = 0;
        l = 1;
        while (!res_valid && l < 300) begin
            @(negedge clk);
            l++;
        end
        chk("res_valid_seen", {31'b0, res_valid}, 32'd1);
    endtask

    task automatic finish_res();
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("hs_res_valid", {31'b0, res_valid}, 32'd0);
        chk("hs_job_ready", {31'b0, job_ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_job_ready", {31'b0, job_ready}, 32'd1);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_strobes", {30'b0, srd, swr}, 32'd0);
        chk("rst_saddress", {16'h0, saddress}, 32'd0);
        chk("rst_sdata_out", sdata_out, 32'd0);
        chk("rst_res_w", res_w, 32'd0);
        chk("rst_res_l", {8'h0, res_l}, 32'd0);
        chk("rst_timeout", {31'b0, res_timeout}, 32'd0);
        n_reset = 1;
        mon_en = 1;

        // 3*5, done on first poll
        nr0 = nr; nw0 = nw;
        run_job(24'd3, 24'd5, lat);
        chk("j1_latency", 32'(lat), 32'd35);
        chk("j1_res_w", res_w, 32'd15);
        chk("j1_res_l", {8'h0, res_l}, 32'd4);
        chk("j1_timeout", {31'b0, res_timeout}, 32'd0);
        chk("j1_busy", {31'b0, busy}, 32'd1);
        chk("j1_job_ready", {31'b0, job_ready}, 32'd0);
        chk("j1_nwr", 32'(nw - nw0), 32'd3);
        chk("j1_wa0", {16'h0, wa[nw0]}, 32'h0380);
        chk("j1_wd0", wd[nw0], 32'd3);
        chk("j1_wa1", {16'h0, wa[nw0+1]}, 32'h0388);
        chk("j1_wd1", wd[nw0+1], 32'd5);
        chk("j1_wa2", {16'h0, wa[nw0+2]}, 32'h03A0);
        chk("j1_wd2", wd[nw0+2], 32'd1);
        chk("j1_nrd", 32'(nr - nr0), 32'd3);
        chk("j1_ra0", {16'h0, rlog[nr0]}, 32'h03A0);
        chk("j1_ra1", {16'h0, rlog[nr0+1]}, 32'h0390);
        chk("j1_ra2", {16'h0, rlog[nr0+2]}, 32'h0398);
        finish_res();
        chk("j1_hold_res_w", res_w, 32'd15);

        // Full-scale operands
        run_job(24'hFFFFFF, 24'hFFFFFF, lat);
        chk("j2_res_w", res_w, 32'hFE000001);
        chk("j2_res_l", {8'h0, res_l}, 32'd8);
        chk("j2_timeout", {31'b0, res_timeout}, 32'd0);
        finish_res();

        // Status 01 for three polls, then done
        busy_stat = 2'b01; busy_polls = 3;
        nr0 = nr;
        run_job(24'd7, 24'd9, lat);
        chk("j3_latency", 32'(lat), 32'd53);
        chk("j3_nrd", 32'(nr - nr0), 32'd6);
        chk("j3_ra3", {16'h0, rlog[nr0+3]}, 32'h03A0);
        chk("j3_ra4", {16'h0, rlog[nr0+4]}, 32'h0390);
        chk("j3_res_w", res_w, 32'd63);
        chk("j3_res_l", {8'h0, res_l}, 32'd6);
        busy_polls = 0;

        // Backpressure on the result port; a job pulse must be ignored
        for (int i = 0; i < 10; i++) begin
            job_valid = (i == 4);
            job_a1 = 24'd1;
            @(negedge clk);
            chk("stall_res_w", res_w, 32'd63);
            chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
            chk("stall_job_ready", {31'b0, job_ready}, 32'd0);
        end
        job_valid = 0;
        finish_res();
        chk("stall_res_w_after", res_w, 32'd63);
        @(negedge clk);
        chk("stall_not_accepted", {31'b0, busy}, 32'd0);

        // Status stuck at 00 -> timeout after 4 polls
        stuck = 1; busy_stat = 2'b00;
        nr0 = nr;
        run_job(24'd4, 24'd4, lat);
        chk("to_latency", 32'(lat), 32'd41);
        chk("to_nrd", 32'(nr - nr0), 32'd4);
        chk("to_ra3", {16'h0, rlog[nr0+3]}, 32'h03A0);
        chk("to_timeout", {31'b0, res_timeout}, 32'd1);
        chk("to_res_w", res_w, 32'd0);
        chk("to_res_l", {8'h0, res_l}, 32'd0);
        finish_res();
        stuck = 0;

        // Reset during WR_A2 strobe
        @(negedge clk);
        job_a1 = 24'd2; job_a2 = 24'd3; job_valid = 1;
        @(negedge clk);
        job_valid = 0;
        repeat (7) @(negedge clk);
        chk("mid_swr", {31'b0, swr}, 32'd1);
        chk("mid_saddress", {16'h0, saddress}, 32'h0388);
        n_reset = 0; mon_en = 0;
        @(negedge clk);
        chk("mrst_swr", {31'b0, swr}, 32'd0);
        chk("mrst_saddress", {16'h0, saddress}, 32'd0);
        chk("mrst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("mrst_job_ready", {31'b0, job_ready}, 32'd1);
        n_reset = 1;
        @(negedge clk);
        mon_en = 1;
        chk("mrst_rel_job_ready", {31'b0, job_ready}, 32'd1);
        nw0 = nw;
        run_job(24'd2, 24'd3, lat);
        chk("mrst_latency", 32'(lat), 32'd35);
        chk("mrst_nwr", 32'(nw - nw0), 32'd3);
        chk("mrst_res_w", res_w, 32'd6);
        chk("mrst_res_l", {8'h0, res_l}, 32'd2);
        finish_res();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
